// File: rtl/ensemble_vote_combiner.sv
// ensemble_vote_combiner: aligns three classifier result streams beat-by-beat and emits a majority-voted prediction with statistics.
module ensemble_vote_combiner #(
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_WIDTH  = 4,
    parameter int CLASS_WIDTH = 8,
    parameter int TIE_LANE    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
    input  logic                  s_axis_tvalid_0,
    output logic                  s_axis_tready_0,
    input  logic                  s_axis_tlast_0,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
    input  logic                  s_axis_tvalid_1,
    output logic                  s_axis_tready_1,
    input  logic                  s_axis_tlast_1,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
    input  logic                  s_axis_tvalid_2,
    output logic                  s_axis_tready_2,
    input  logic                  s_axis_tlast_2,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [31:0]           vote_count,
    output logic [31:0]           disagree_count,
    output logic                  tlast_mismatch
);
    logic [2:0] full_q, full_d, last_q, last_d, valid_in, last_in, ready, acc;
    logic [CLASS_WIDTH-1:0] cls_q [3];
    logic [CLASS_WIDTH-1:0] cls_d [3];
    logic [CLASS_WIDTH-1:0] din [3];
    logic fire, drain, e01, e02, e12;
    logic [CLASS_WIDTH-1:0] winner;
    logic [1:0] agree;
    logic [DATA_WIDTH-1:0] vote_data, out_data_q, out_data_d;
    logic [KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
    logic out_valid_q, out_valid_d, out_last_q, out_last_d, mism_q, mism_d;
    logic [31:0] vote_q, vote_d, dis_q, dis_d;
    logic unused_in;

    assign unused_in = ^{s_axis_tdata_0[DATA_WIDTH-1:CLASS_WIDTH], s_axis_tdata_1[DATA_WIDTH-1:CLASS_WIDTH],
                         s_axis_tdata_2[DATA_WIDTH-1:CLASS_WIDTH], s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2};

    assign valid_in = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
    assign last_in  = {s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};
    assign din[0]   = s_axis_tdata_0[CLASS_WIDTH-1:0];
    assign din[1]   = s_axis_tdata_1[CLASS_WIDTH-1:0];
    assign din[2]   = s_axis_tdata_2[CLASS_WIDTH-1:0];

    // Ready depends only on held state and the output stage, never on tvalid.
    assign fire  = &full_q & (~out_valid_q | m_axis_tready);
    assign drain = out_valid_q & m_axis_tready & ~fire;
    assign ready = ~full_q | {3{fire}};
    assign acc   = valid_in & ready;
    assign {s_axis_tready_2, s_axis_tready_1, s_axis_tready_0} = ready;

    assign e01    = cls_q[0] == cls_q[1];
    assign e02    = cls_q[0] == cls_q[2];
    assign e12    = cls_q[1] == cls_q[2];
    assign winner = (e01 | e02) ? cls_q[0] : e12 ? cls_q[1] : cls_q[TIE_LANE];
    assign agree  = (e01 & e02) ? 2'd3 : (e01 | e02 | e12) ? 2'd2 : 2'd1;

    always_comb begin
        vote_data = '0;
        vote_data[CLASS_WIDTH-1:0] = winner;
        vote_data[17:16] = agree;
        full_d = (full_q & ~{3{fire}}) | acc;
        last_d = (last_q & ~acc) | (last_in & acc);
        for (int i = 0; i < 3; i++) cls_d[i] = acc[i] ? din[i] : cls_q[i];
        out_valid_d = fire | (out_valid_q & ~m_axis_tready);
        out_data_d  = fire ? vote_data : drain ? '0 : out_data_q;
        out_keep_d  = fire ? '1 : drain ? '0 : out_keep_q;
        out_last_d  = fire ? last_q[0] : drain ? 1'b0 : out_last_q;
        vote_d = vote_q + 32'(fire);
        dis_d  = dis_q + 32'(fire & (agree != 2'd3));
        mism_d = mism_q | (fire & ~(&last_q | ~|last_q));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q      <= '0;
            last_q      <= '0;
            for (int i = 0; i < 3; i++) cls_q[i] <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            vote_q      <= '0;
            dis_q       <= '0;
            mism_q      <= 1'b0;
        end else begin
            full_q      <= full_d;
            last_q      <= last_d;
            for (int i = 0; i < 3; i++) cls_q[i] <= cls_d[i];
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            vote_q      <= vote_d;
            dis_q       <= dis_d;
            mism_q      <= mism_d;
        end
    end

    assign m_axis_tvalid  = out_valid_q;
    assign m_axis_tdata   = out_data_q;
    assign m_axis_tkeep   = out_keep_q;
    assign m_axis_tlast   = out_last_q;
    assign vote_count     = vote_q;
    assign disagree_count = dis_q;
    assign tlast_mismatch = mism_q;
endmodule

// File: tb/tb_ensemble_vote_combiner.sv
// tb_ensemble_vote_combiner: directed stimulus with a scoreboard of expected voted beats.
module tb_ensemble_vote_combiner;
    logic clk = 0, rst_n = 0;
    logic [31:0] td0 = 0, td1 = 0, td2 = 0, m_data, vcnt, dcnt;
    logic [3:0] tk0 = 4'hF, tk1 = 4'h3, tk2 = 4'h0, m_keep;
    logic v0 = 0, v1 = 0, v2 = 0, l0 = 0, l1 = 0, l2 = 0, r0, r1, r2;
    logic m_valid, m_ready = 1, m_last, mism;
    int total = 0, bad = 0, outs = 0, cyc = 0;
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ensemble_vote_combiner dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata_0(td0), .s_axis_tkeep_0(tk0), .s_axis_tvalid_0(v0), .s_axis_tready_0(r0), .s_axis_tlast_0(l0),
        .s_axis_tdata_1(td1), .s_axis_tkeep_1(tk1), .s_axis_tvalid_1(v1), .s_axis_tready_1(r1), .s_axis_tlast_1(l1),
        .s_axis_tdata_2(td2), .s_axis_tkeep_2(tk2), .s_axis_tvalid_2(v2), .s_axis_tready_2(r2), .s_axis_tlast_2(l2),
        .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
        .m_axis_tlast(m_last), .vote_count(vcnt), .disagree_count(dcnt), .tlast_mismatch(mism)
    );

    // Count how many lanes share each lane's class; the largest group wins, lane 2 on a three-way split.
    function automatic logic [31:0] model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] cl [3];
        int n [3];
        int best;
        cl = '{a, b, c};
        for (int i = 0; i < 3; i++) begin
            n[i] = 0;
            for (int j = 0; j < 3; j++) if (cl[j] == cl[i]) n[i]++;
        end
        best = 2;
        for (int i = 2; i >= 0; i--) if (n[i] > n[best]) best = i;
        return {14'd0, 2'(n[best]), 8'd0, cl[best]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] mask, input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                        input logic [2:0] l, input bit push);
        logic [2:0] pend, a;
        td0 = {24'hA5A5A5, c0};
        td1 = {24'h5A5A5A, c1};
        td2 = {24'hFFFFFF, c2};
        {l2, l1, l0} = l;
        pend = mask;
        {v2, v1, v0} = pend;
        if (push) exp_q.push_back({l[0], model(c0, c1, c2)});
        for (int k = 0; k < 50 && pend != 0; k++) begin
            @(negedge clk);
            a = pend & {r2, r1, r0};
            @(posedge clk);
            #1;
            pend = pend & ~a;
            {v2, v1, v0} = pend;
        end
        chk("send_accept", 64'(pend), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            logic [32:0] e;
            outs++;
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL out_unexpected got=%0h exp=none", m_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                assert ({m_last, m_data} === e) else begin
                    bad++;
                    $error("FAIL out_beat got=%0h exp=%0h", {m_last, m_data}, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, o0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(m_valid), 0);
        chk("rst_data", 64'(m_data), 0);
        chk("rst_keep", 64'(m_keep), 0);
        chk("rst_last", 64'(m_last), 0);
        chk("rst_votes", 64'(vcnt), 0);
        chk("rst_disagree", 64'(dcnt), 0);
        chk("rst_mismatch", 64'(mism), 0);
        step();
        rst_n = 1;
        @(negedge clk);
        chk("rst_ready", 64'({r2, r1, r0}), 64'b111);
        step();

        send(3'b111, 8'd5, 8'd5, 8'd5, 3'b111, 1);
        @(negedge clk);
        chk("lat_t1_valid", 64'(m_valid), 0);
        @(negedge clk);
        chk("lat_t2_valid", 64'(m_valid), 1);
        chk("unan_data", 64'(m_data), 64'h0003_0005);
        chk("unan_last", 64'(m_last), 1);
        chk("unan_keep", 64'(m_keep), 64'hF);
        repeat (3) step();
        chk("unan_votes", 64'(vcnt), 1);
        chk("unan_disagree", 64'(dcnt), 0);

        send(3'b111, 8'd3, 8'd7, 8'd3, 3'b000, 1);
        send(3'b111, 8'd1, 8'd2, 8'd4, 3'b000, 1);
        repeat (4) step();
        chk("maj_votes", 64'(vcnt), 3);
        chk("maj_disagree", 64'(dcnt), 2);

        exp_q.push_back({1'b1, model(8'd6, 8'd2, 8'd6)});
        l0 = 1; l1 = 1; l2 = 1;
        for (int k = 0; k <= 16; k++) begin
            v0 = k <= 9;
            td0 = k == 0 ? 32'd6 : 32'd11;
            v2 = k == 4;
            td2 = 32'd6;
            v1 = k == 9;
            td1 = 32'd2;
            m_ready = k == 15;
            @(negedge clk);
            if (k >= 1 && k <= 9) chk("skew_ready0_low", 64'(r0), 0);
            if (k == 10 || k == 16) chk("skew_valid_low", 64'(m_valid), 0);
            if (k >= 11 && k <= 15) begin
                chk("skew_valid_hold", 64'(m_valid), 1);
                chk("skew_data_hold", 64'(m_data), 64'h0002_0006);
            end
            step();
        end
        v0 = 0; v1 = 0; v2 = 0;
        m_ready = 1;

        o0 = outs;
        t0 = cyc;
        for (int i = 0; i < 100; i++)
            send(3'b111, 8'(i % 5), 8'((i * 3) % 5), 8'(i % 7), {3{i == 99}}, 1);
        chk("stream_cycles", 64'(cyc - t0), 100);
        repeat (4) step();
        chk("stream_outs", 64'(outs - o0), 100);
        chk("stream_votes", 64'(vcnt), 104);

        chk("mism_before", 64'(mism), 0);
        send(3'b111, 8'd4, 8'd4, 8'd4, 3'b101, 1);
        send(3'b111, 8'd1, 8'd1, 8'd1, 3'b000, 1);
        repeat (4) step();
        chk("mism_sticky", 64'(mism), 1);

        m_ready = 0;
        send(3'b111, 8'd2, 8'd2, 8'd2, 3'b000, 0);
        send(3'b011, 8'd9, 8'd9, 8'd0, 3'b000, 0);
        @(negedge clk);
        chk("pre_rst_pending", 64'(m_valid), 1);
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        exp_q.delete();
        o0 = outs;
        @(negedge clk);
        chk("mid_rst_valid", 64'(m_valid), 0);
        chk("mid_rst_data", 64'(m_data), 0);
        chk("mid_rst_keep", 64'(m_keep), 0);
        chk("mid_rst_votes", 64'(vcnt), 0);
        chk("mid_rst_mismatch", 64'(mism), 0);
        chk("mid_rst_ready", 64'({r2, r1, r0}), 64'b111);
        step();
        m_ready = 1;
        send(3'b111, 8'd8, 8'd8, 8'd1, 3'b000, 1);
        repeat (5) step();
        chk("post_rst_outs", 64'(outs - o0), 1);
        chk("post_rst_votes", 64'(vcnt), 1);
        chk("post_rst_disagree", 64'(dcnt), 1);
        chk("scoreboard_empty", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
